theta_meta_monitor: RTL and testbench

//  Downstream of pst_brain_v2's episode stage. Samples one theta episode summary (winner,

---
 rtl/pst_pkg.sv | 14 +
 rtl/ep_hist_fifo.sv | 49 ++++
 rtl/theta_meta_monitor.sv | 99 +++++++++
 tb/tb_theta_meta_monitor.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pst_pkg.sv
// Shared types and widths for the pst_brain_v2 episode path.
package pst_pkg;
  localparam int         EP_WIN_W = 3;
  localparam int         EP_STR_W = 4;
  localparam int         CONF_W   = 2;
  localparam logic [1:0] CONF_MAX = 2'd3;

  // One history record: did the winner change, who won, how strongly.
  typedef struct packed {
    logic                switch;
    logic [EP_WIN_W-1:0] winner;
    logic [EP_STR_W-1:0] strength;
  } ep_hist_t;
endpackage

// File: rtl/ep_hist_fifo.sv
// Episode history FIFO: first-word-fall-through read, drops pushes when full
// unless a pop frees a slot in the same cycle.
module ep_hist_fifo
  import pst_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  ep_hist_t      din,
  input  logic          pop,
  output ep_hist_t      dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);
  ep_hist_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            do_pop, do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Oldest entry is always presented; it only moves when popped.
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH (power of 2).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/theta_meta_monitor.sv
// Theta-rate meta monitor: confidence tracking, exploit/explore modes,
// explore-entry context gate, and an episode history drain port.
module theta_meta_monitor
  import pst_pkg::*;
#(
  parameter logic [3:0] STR_MAX    = 4'd8,
  parameter logic [3:0] STR_HI     = 4'd7,
  parameter logic [3:0] STR_LO     = 4'd5,
  parameter logic [1:0] CONF_RST   = 2'd2,
  parameter logic [1:0] EXPL_THR   = 2'd1,
  parameter int         HIST_DEPTH = 8,
  localparam int        CW         = $clog2(HIST_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                theta_tick,
  input  logic                ep_valid,
  input  logic [EP_WIN_W-1:0] ep_winner,
  input  logic [EP_STR_W-1:0] ep_strength,
  input  logic                hist_ready,
  output logic [CONF_W-1:0]   confidence_level,
  output logic                exploit_mode,
  output logic                explore_mode,
  output logic                ctx_gate,
  output logic                hist_valid,
  output logic [7:0]          hist_data,
  output logic [CW-1:0]       hist_count,
  output logic                hist_overflow
);
  logic                samp, sw, prev_valid, explore_nxt;
  logic [EP_WIN_W-1:0] prev_winner;
  logic [EP_STR_W-1:0] str_c;
  logic signed [3:0]   delta, sum;
  logic [CONF_W-1:0]   conf_nxt;
  logic                fifo_empty, fifo_full;
  ep_hist_t            fifo_din, fifo_dout;

  assign samp  = theta_tick & ep_valid;
  assign str_c = (ep_strength > STR_MAX) ? STR_MAX : ep_strength;
  assign sw    = prev_valid & (ep_winner != prev_winner);

  // Confidence step for this episode, saturated into 0..CONF_MAX.
  always_comb begin
    delta = 4'sd0;
    if (str_c >= STR_HI) delta = delta + 4'sd1;
    if (str_c <= STR_LO) delta = delta - 4'sd1;
    if (sw)              delta = delta - 4'sd1;
    sum = $signed({2'b00, confidence_level}) + delta;
    if (sum < 4'sd0)                       conf_nxt = '0;
    else if (sum > $signed({2'b00, CONF_MAX})) conf_nxt = CONF_MAX;
    else                                   conf_nxt = sum[CONF_W-1:0];
    explore_nxt = (conf_nxt <= EXPL_THR);
  end

  // Mode registers update only on a sample; ctx_gate fires on explore entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      confidence_level <= CONF_RST;
      exploit_mode     <= 1'b0;
      explore_mode     <= 1'b0;
      ctx_gate         <= 1'b0;
      prev_valid       <= 1'b0;
      prev_winner      <= '0;
    end else begin
      ctx_gate <= 1'b0;
      if (samp) begin
        confidence_level <= conf_nxt;
        exploit_mode     <= (conf_nxt == CONF_MAX);
        explore_mode     <= explore_nxt;
        ctx_gate         <= explore_nxt & ~explore_mode;
        prev_valid       <= 1'b1;
        prev_winner      <= ep_winner;
      end
    end
  end

  // Sticky drop flag: a sample arrived while full with no pop to make room.
  always_ff @(posedge clk) begin
    if (rst) hist_overflow <= 1'b0;
    else if (samp && fifo_full && !hist_ready) hist_overflow <= 1'b1;
  end

  assign fifo_din = '{switch: sw, winner: ep_winner, strength: str_c};

  ep_hist_fifo #(.DEPTH(HIST_DEPTH)) u_hist (
    .clk   (clk),
    .rst   (rst),
    .push  (samp),
    .din   (fifo_din),
    .pop   (hist_ready),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (hist_count)
  );

  assign hist_valid = ~fifo_empty;
  assign hist_data  = fifo_dout;
endmodule

// File: tb/tb_theta_meta_monitor.sv
// Bench for theta_meta_monitor: directed vector table, hand sequences for
// FIFO fill/drain and reset corners, then random traffic vs a queue model.
module tb_theta_meta_monitor;
  logic       clk = 1'b0, rst = 1'b1, theta_tick = 1'b0, ep_valid = 1'b0, hist_ready = 1'b0;
  logic [2:0] ep_winner = '0;
  logic [3:0] ep_strength = '0;
  logic [1:0] confidence_level;
  logic       exploit_mode, explore_mode, ctx_gate, hist_valid, hist_overflow;
  logic [7:0] hist_data;
  logic [3:0] hist_count;

  theta_meta_monitor dut (
    .clk(clk), .rst(rst), .theta_tick(theta_tick), .ep_valid(ep_valid),
    .ep_winner(ep_winner), .ep_strength(ep_strength), .hist_ready(hist_ready),
    .confidence_level(confidence_level), .exploit_mode(exploit_mode),
    .explore_mode(explore_mode), .ctx_gate(ctx_gate), .hist_valid(hist_valid),
    .hist_data(hist_data), .hist_count(hist_count), .hist_overflow(hist_overflow)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Behavioural model: integer confidence, last winner, history as a queue.
  int         m_conf = 2, m_pw = 0;
  bit         m_pv = 0, m_ovf = 0, m_ctx = 0;
  logic [7:0] q[$];

  task automatic model_step(input logic r, t, v, input logic [2:0] w, input logic [3:0] s,
                            input logic rdy);
    int  sc, d, old;
    bit  sw, smp, pop;
    if (r) begin
      m_conf = 2; m_pv = 0; m_pw = 0; m_ovf = 0; m_ctx = 0; q.delete();
      return;
    end
    smp = t && v;
    sc  = (s > 8) ? 8 : int'(s);
    sw  = m_pv && (int'(w) != m_pw);
    pop = (q.size() > 0) && rdy;
    if (pop) void'(q.pop_front());
    m_ctx = 0;
    if (smp) begin
      if (q.size() < 8) q.push_back({sw, w, 4'(sc)});
      else m_ovf = 1;
      d = 0;
      if (sc >= 7) d += 1;
      if (sc <= 5) d -= 1;
      if (sw) d -= 1;
      old = m_conf;
      m_conf = m_conf + d;
      if (m_conf < 0) m_conf = 0;
      if (m_conf > 3) m_conf = 3;
      m_ctx = (m_conf <= 1) && (old > 1);
      m_pv = 1; m_pw = int'(w);
    end
  endtask

  task automatic check_model();
    chk("conf", confidence_level, m_conf);
    chk("exploit", exploit_mode, m_conf == 3);
    chk("explore", explore_mode, m_conf <= 1);
    chk("ctx_gate", ctx_gate, m_ctx);
    chk("hist_valid", hist_valid, q.size() > 0);
    chk("hist_count", hist_count, q.size());
    chk("overflow", hist_overflow, m_ovf);
    if (q.size() > 0) chk("hist_data", hist_data, q[0]);
  endtask

  task automatic cyc(input logic r, t, v, input logic [2:0] w, input logic [3:0] s,
                     input logic rdy);
    rst = r; theta_tick = t; ep_valid = v; ep_winner = w; ep_strength = s; hist_ready = rdy;
    model_step(r, t, v, w, s, rdy);
    @(posedge clk); #1;
    check_model();
  endtask

  typedef struct {
    logic       tick, valid;
    logic [2:0] win;
    logic [3:0] str;
    logic [1:0] conf;
    logic       ctx;
    logic [3:0] cnt;
    logic [7:0] data;
  } vec_t;

  vec_t tv[18];

  initial begin
    tv[0]  = '{1, 1, 3'd0, 4'd8,  2'd3, 0, 4'd1, 8'h08};
    tv[1]  = '{1, 1, 3'd0, 4'd8,  2'd3, 0, 4'd1, 8'h08};
    tv[2]  = '{1, 1, 3'd0, 4'd8,  2'd3, 0, 4'd1, 8'h08};
    tv[3]  = '{1, 1, 3'd2, 4'd4,  2'd1, 1, 4'd1, 8'hA4};
    tv[4]  = '{1, 1, 3'd0, 4'd4,  2'd0, 0, 4'd1, 8'h84};
    tv[5]  = '{1, 1, 3'd2, 4'd4,  2'd0, 0, 4'd1, 8'hA4};
    tv[6]  = '{1, 1, 3'd1, 4'd6,  2'd0, 0, 4'd1, 8'h96};
    tv[7]  = '{1, 1, 3'd1, 4'd6,  2'd0, 0, 4'd1, 8'h16};
    tv[8]  = '{1, 1, 3'd1, 4'd12, 2'd1, 0, 4'd1, 8'h18};
    tv[9]  = '{1, 1, 3'd1, 4'd7,  2'd2, 0, 4'd1, 8'h17};
    tv[10] = '{1, 1, 3'd1, 4'd7,  2'd3, 0, 4'd1, 8'h17};
    tv[11] = '{1, 1, 3'd1, 4'd5,  2'd2, 0, 4'd1, 8'h15};
    tv[12] = '{1, 0, 3'd3, 4'd8,  2'd2, 0, 4'd0, 8'h00};
    tv[13] = '{0, 1, 3'd5, 4'd8,  2'd2, 0, 4'd0, 8'h00};
    tv[14] = '{1, 1, 3'd1, 4'd6,  2'd2, 0, 4'd1, 8'h16};
    tv[15] = '{1, 1, 3'd3, 4'd6,  2'd1, 1, 4'd1, 8'hB6};
    tv[16] = '{1, 1, 3'd3, 4'd7,  2'd2, 0, 4'd1, 8'h37};
    tv[17] = '{1, 1, 3'd3, 4'd3,  2'd1, 1, 4'd1, 8'h33};

    // Reset held two cycles.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_conf", confidence_level, 2'd2);
    chk("rst_hist_valid", hist_valid, 1'b0);
    chk("rst_overflow", hist_overflow, 1'b0);

    // Directed table with the drain port always ready.
    for (int i = 0; i < 18; i++) begin
      cyc(0, tv[i].tick, tv[i].valid, tv[i].win, tv[i].str, 1);
      chk($sformatf("tbl%0d_conf", i), confidence_level, tv[i].conf);
      chk($sformatf("tbl%0d_ctx", i), ctx_gate, tv[i].ctx);
      chk($sformatf("tbl%0d_cnt", i), hist_count, tv[i].cnt);
      if (tv[i].cnt != 0) chk($sformatf("tbl%0d_data", i), hist_data, tv[i].data);
    end

    // Fill past full with the consumer stalled.
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) cyc(0, 1, 1, 3'(i), 4'(i), 0);
    chk("full_count", hist_count, 4'd8);
    chk("full_overflow", hist_overflow, 1'b1);
    chk("full_head", hist_data, 8'h80);
    // Push and pop together while full.
    cyc(0, 1, 1, 3'd1, 4'd5, 1);
    chk("pushpop_count", hist_count, 4'd8);
    chk("pushpop_head", hist_data, 8'h91);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 1);
    chk("drained_valid", hist_valid, 1'b0);
    chk("drained_overflow_sticky", hist_overflow, 1'b1);

    // Reset in the middle of a drain.
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 3'(i + 2), 4'd7, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    chk("midrst_count", hist_count, 4'd0);
    chk("midrst_conf", confidence_level, 2'd2);
    cyc(0, 1, 1, 3'd5, 4'd8, 0);
    chk("post_rst_switch", hist_data[7], 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 1), $urandom_range(0, 3) != 0,
          3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), $urandom_range(0, 1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
